// File: rtl/csi2_pkt_ctrl.sv
// CSI-2 packet sequencer: parses headers, forwards long-packet payload with byte keeps,
// and re-arms the PHY aligner. Optional header ECC check: CSI2_PKT_CTRL_ECC_CHECK_EN.
module csi2_pkt_ctrl #(
  parameter logic [15:0] MAX_WC         = 16'd4096,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  SHORT_DT_MAX   = 8'h0F
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        phy_enable_o,
  output logic        wait_for_sync_o,
  output logic        pkt_done_o,
  output logic        hdr_valid_o,
  output logic [7:0]  hdr_data_id_o,
  output logic [15:0] hdr_wc_o,
  output logic [31:0] pl_data_o,
  output logic [3:0]  pl_keep_o,
  output logic        pl_valid_o,
  output logic        pl_last_o,
  output logic        err_wc_o,
  output logic        err_timeout_o,
  output logic        err_ecc_o
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_DISABLED, S_SYNC_WAIT, S_PAYLOAD} state_t;

  state_t            r_state;
  logic [16:0]       r_bytes_left;
  logic [16:0]       r_words_left;
  logic [IDLE_W-1:0] r_idle;
  logic              r_last_sent;
  logic              r_phy_enable, r_wait_for_sync, r_pkt_done, r_hdr_valid;
  logic [7:0]        r_hdr_di;
  logic [15:0]       r_hdr_wc;
  logic [31:0]       r_pl_data;
  logic [3:0]        r_pl_keep;
  logic              r_pl_valid, r_pl_last, r_err_wc, r_err_timeout;

  logic [5:0]  w_dt;
  logic [15:0] w_wc;
  logic        w_short, w_wc_bad, w_idle_hit, w_last_beat;
  logic [16:0] w_words;
  logic [2:0]  w_take;
  logic [3:0]  w_keep;

  assign w_dt     = data_i[5:0];
  assign w_wc     = data_i[23:8];
  assign w_short  = ({2'b00, w_dt} <= SHORT_DT_MAX);
  assign w_wc_bad = (w_wc == 16'd0) || (w_wc > MAX_WC);
  // ceil((WC + 2) / 4): payload plus the two CRC bytes
  assign w_words  = ({1'b0, w_wc} + 17'd5) >> 2;
  assign w_take   = (r_bytes_left >= 17'd4) ? 3'd4 : r_bytes_left[2:0];
  assign w_last_beat = (r_bytes_left != 17'd0) && (r_bytes_left <= 17'd4);
  assign w_idle_hit  = (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_keep = 4'h0;
    case (w_take)
      3'd1:    w_keep = 4'h1;
      3'd2:    w_keep = 4'h3;
      3'd3:    w_keep = 4'h7;
      3'd4:    w_keep = 4'hF;
      default: w_keep = 4'h0;
    endcase
  end

`ifdef CSI2_PKT_CTRL_ECC_CHECK_EN
  localparam logic [23:0] ECC_M0 = 24'hF12CB7;
  localparam logic [23:0] ECC_M1 = 24'hF2555B;
  localparam logic [23:0] ECC_M2 = 24'h749A6D;
  localparam logic [23:0] ECC_M3 = 24'hB8E38E;
  localparam logic [23:0] ECC_M4 = 24'hDF03F0;
  localparam logic [23:0] ECC_M5 = 24'hEFFC00;
  logic [5:0] w_ecc_calc;
  logic       w_ecc_ok;
  logic       r_err_ecc;
  assign w_ecc_calc = {^(data_i[23:0] & ECC_M5), ^(data_i[23:0] & ECC_M4),
                       ^(data_i[23:0] & ECC_M3), ^(data_i[23:0] & ECC_M2),
                       ^(data_i[23:0] & ECC_M1), ^(data_i[23:0] & ECC_M0)};
  assign w_ecc_ok   = (w_ecc_calc == data_i[29:24]) && (data_i[31:30] == 2'b00);
  assign err_ecc_o  = r_err_ecc;
`else
  assign err_ecc_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state         <= S_DISABLED;
      r_bytes_left    <= '0;
      r_words_left    <= '0;
      r_idle          <= '0;
      r_last_sent     <= 1'b0;
      r_phy_enable    <= 1'b0;
      r_wait_for_sync <= 1'b1;
      r_pkt_done      <= 1'b0;
      r_hdr_valid     <= 1'b0;
      r_hdr_di        <= '0;
      r_hdr_wc        <= '0;
      r_pl_data       <= '0;
      r_pl_keep       <= '0;
      r_pl_valid      <= 1'b0;
      r_pl_last       <= 1'b0;
      r_err_wc        <= 1'b0;
      r_err_timeout   <= 1'b0;
`ifdef CSI2_PKT_CTRL_ECC_CHECK_EN
      r_err_ecc       <= 1'b0;
`endif
    end else begin
      r_pkt_done    <= 1'b0;
      r_hdr_valid   <= 1'b0;
      r_pl_valid    <= 1'b0;
      r_pl_last     <= 1'b0;
      r_pl_keep     <= 4'h0;
      r_err_wc      <= 1'b0;
      r_err_timeout <= 1'b0;
`ifdef CSI2_PKT_CTRL_ECC_CHECK_EN
      r_err_ecc     <= 1'b0;
`endif
      if (!enable_i) begin
        // disable wins over a coincident beat; an open packet is closed with an abort beat
        if (r_state == S_PAYLOAD && !r_last_sent) begin
          r_pl_valid <= 1'b1;
          r_pl_last  <= 1'b1;
          r_pl_data  <= '0;
        end
        r_state         <= S_DISABLED;
        r_phy_enable    <= 1'b0;
        r_wait_for_sync <= 1'b1;
        r_idle          <= '0;
      end else begin
        case (r_state)
          S_DISABLED: begin
            r_state      <= S_SYNC_WAIT;
            r_phy_enable <= 1'b1;
            r_idle       <= '0;
          end
          S_SYNC_WAIT: begin
            if (valid_i) begin
`ifdef CSI2_PKT_CTRL_ECC_CHECK_EN
              if (!w_ecc_ok) begin
                r_err_ecc  <= 1'b1;
                r_pkt_done <= 1'b1;
              end else
`endif
              begin
                r_hdr_valid <= 1'b1;
                r_hdr_di    <= data_i[7:0];
                r_hdr_wc    <= w_wc;
                if (w_short) begin
                  r_pkt_done <= 1'b1;
                end else if (w_wc_bad) begin
                  r_err_wc   <= 1'b1;
                  r_pkt_done <= 1'b1;
                end else begin
                  r_bytes_left    <= {1'b0, w_wc};
                  r_words_left    <= w_words;
                  r_last_sent     <= 1'b0;
                  r_idle          <= '0;
                  r_state         <= S_PAYLOAD;
                  r_wait_for_sync <= 1'b0;
                end
              end
            end
          end
          S_PAYLOAD: begin
            if (valid_i) begin
              r_idle       <= '0;
              r_pl_data    <= data_i;
              r_pl_keep    <= w_keep;
              r_pl_valid   <= |w_keep;
              r_pl_last    <= w_last_beat;
              r_bytes_left <= r_bytes_left - {14'd0, w_take};
              r_words_left <= r_words_left - 17'd1;
              if (w_last_beat) r_last_sent <= 1'b1;
              if (r_words_left == 17'd1) begin
                r_pkt_done      <= 1'b1;
                r_wait_for_sync <= 1'b1;
                r_state         <= S_SYNC_WAIT;
              end
            end else if (w_idle_hit) begin
              r_err_timeout   <= 1'b1;
              r_pkt_done      <= 1'b1;
              r_wait_for_sync <= 1'b1;
              r_state         <= S_SYNC_WAIT;
              r_idle          <= '0;
              if (!r_last_sent) begin
                r_pl_valid <= 1'b1;
                r_pl_last  <= 1'b1;
                r_pl_data  <= '0;
              end
            end else begin
              r_idle <= r_idle + 1'b1;
            end
          end
          default: r_state <= S_DISABLED;
        endcase
      end
    end
  end

  assign phy_enable_o    = r_phy_enable;
  assign wait_for_sync_o = r_wait_for_sync;
  assign pkt_done_o      = r_pkt_done;
  assign hdr_valid_o     = r_hdr_valid;
  assign hdr_data_id_o   = r_hdr_di;
  assign hdr_wc_o        = r_hdr_wc;
  assign pl_data_o       = r_pl_data;
  assign pl_keep_o       = r_pl_keep;
  assign pl_valid_o      = r_pl_valid;
  assign pl_last_o       = r_pl_last;
  assign err_wc_o        = r_err_wc;
  assign err_timeout_o   = r_err_timeout;
endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// Scoreboard bench for csi2_pkt_ctrl: stimulus pushes expected header/payload/event
// records, a negedge monitor pops and compares whenever the DUT emits something.
module tb_csi2_pkt_ctrl;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  logic        phy_enable, wfs, pkt_done, hdr_valid, pl_valid, pl_last;
  logic        err_wc, err_to, err_ecc;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic [31:0] pl_data;
  logic [3:0]  pl_keep;

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] hdr_q[$];   // {di, wc}
  logic [36:0] pl_q[$];    // {last, keep, data}
  logic [3:0]  ev_q[$];    // {done, err_wc, err_timeout, err_ecc}

  csi2_pkt_ctrl #(.MAX_WC(16'd4096), .TIMEOUT_CYCLES(TO), .SHORT_DT_MAX(8'h0F)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .data_i(data), .valid_i(valid),
    .phy_enable_o(phy_enable), .wait_for_sync_o(wfs), .pkt_done_o(pkt_done),
    .hdr_valid_o(hdr_valid), .hdr_data_id_o(hdr_di), .hdr_wc_o(hdr_wc),
    .pl_data_o(pl_data), .pl_keep_o(pl_keep), .pl_valid_o(pl_valid), .pl_last_o(pl_last),
    .err_wc_o(err_wc), .err_timeout_o(err_to), .err_ecc_o(err_ecc));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CSI-2 header parity, written out term by term
  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
    return {ecc_of({wc, di}), wc, di};
  endfunction

  task automatic beat(input logic [31:0] d);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid) begin
        if (hdr_q.size() == 0) chk("hdr_unexpected", {hdr_di, hdr_wc}, 64'h0);
        else chk("hdr", {hdr_di, hdr_wc}, hdr_q.pop_front());
      end
      if (pl_valid) begin
        if (pl_q.size() == 0) chk("pl_unexpected", {pl_last, pl_keep, pl_data}, 64'h0);
        else chk("pl", {pl_last, pl_keep, pl_data}, pl_q.pop_front());
      end
      if (pkt_done | err_wc | err_to | err_ecc) begin
        if (ev_q.size() == 0) chk("ev_unexpected", {pkt_done, err_wc, err_to, err_ecc}, 64'h0);
        else chk("ev", {pkt_done, err_wc, err_to, err_ecc}, ev_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] h;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_phy_enable", phy_enable, 1'b0);
    chk("rst_wfs", wfs, 1'b1);
    chk("rst_pulses", {pkt_done, hdr_valid, pl_valid, pl_last, err_wc, err_to, err_ecc}, 7'h0);
    chk("rst_keep", pl_keep, 4'h0);
    chk("rst_regs", {hdr_di, hdr_wc, pl_data}, 56'h0);
    rst_n = 1'b1;

    // enable -> phy_enable one cycle later
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("en_phy_enable", phy_enable, 1'b1);
    chk("en_wfs", wfs, 1'b1);

    // short packet: frame start, WC=5
    hdr_q.push_back({8'h00, 16'h0005});
    ev_q.push_back(4'b1000);
    beat(hdr(8'h00, 16'h0005));
    idle(2);

    // long DT=0x2A WC=6: two beats, keep F then 3
    hdr_q.push_back({8'h2A, 16'd6});
    beat(hdr(8'h2A, 16'd6));
    pl_q.push_back({1'b0, 4'hF, 32'h44332211});
    beat(32'h44332211);
    chk("wc6_wfs_low", wfs, 1'b0);
    pl_q.push_back({1'b1, 4'h3, 32'hCCBB6655});
    ev_q.push_back(4'b1000);
    beat(32'hCCBB6655);
    idle(1);
    chk("wc6_wfs_high", wfs, 1'b1);
    idle(1);

    // long WC=4: one data beat, CRC-only word swallowed
    hdr_q.push_back({8'h2A, 16'd4});
    beat(hdr(8'h2A, 16'd4));
    pl_q.push_back({1'b1, 4'hF, 32'hDEADBEEF});
    beat(32'hDEADBEEF);
    ev_q.push_back(4'b1000);
    beat(32'h0000ABCD);
    idle(2);

    // WC above MAX_WC and WC=0: error, no payload
    hdr_q.push_back({8'h2A, 16'd4097});
    ev_q.push_back(4'b1100);
    beat(hdr(8'h2A, 16'd4097));
    hdr_q.push_back({8'h2B, 16'd0});
    ev_q.push_back(4'b1100);
    beat(hdr(8'h2B, 16'd0));
    idle(2);
    chk("wcerr_wfs", wfs, 1'b1);

    // timeout: WC=8, one word then silence; expectation pushed only at the due edge
    hdr_q.push_back({8'h2A, 16'd8});
    beat(hdr(8'h2A, 16'd8));
    pl_q.push_back({1'b0, 4'hF, 32'h01020304});
    beat(32'h01020304);
    idle(1);
    repeat (TO - 1) @(negedge clk);
    @(posedge clk);
    pl_q.push_back({1'b1, 4'h0, 32'h0});
    ev_q.push_back(4'b1010);
    idle(3);
    chk("to_wfs", wfs, 1'b1);

    // enable dropped mid-payload with a coincident beat
    hdr_q.push_back({8'h2A, 16'd8});
    beat(hdr(8'h2A, 16'd8));
    pl_q.push_back({1'b0, 4'hF, 32'hA5A5A5A5});
    beat(32'hA5A5A5A5);
    @(negedge clk);
    enable = 1'b0;
    data   = 32'h5A5A5A5A;
    valid  = 1'b1;
    pl_q.push_back({1'b1, 4'h0, 32'h0});
    @(negedge clk);
    valid = 1'b0;
    chk("dis_phy_enable", phy_enable, 1'b0);
    chk("dis_wfs", wfs, 1'b1);
    // header while disabled is ignored
    @(negedge clk);
    data  = hdr(8'h01, 16'h0007);
    valid = 1'b1;
    idle(3);

    // re-enable, short packet still works
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_phy_enable", phy_enable, 1'b1);
    hdr_q.push_back({8'h41, 16'h1234});
    ev_q.push_back(4'b1000);
    beat(hdr(8'h41, 16'h1234));
    idle(2);

`ifdef CSI2_PKT_CTRL_ECC_CHECK_EN
    h = hdr(8'h2A, 16'd6) ^ 32'h0100_0000;
    ev_q.push_back(4'b1001);
    beat(h);
    idle(2);
    chk("ecc_wfs", wfs, 1'b1);
`else
    h = 32'h0;
`endif

    idle(5);
    chk("hdr_q_drained", hdr_q.size(), 0);
    chk("pl_q_drained", pl_q.size(), 0);
    chk("ev_q_drained", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
